// File: rtl/mouse_pkg.sv
// Kempston mouse shared definitions:
// port addresses, reset constants, guard FSM states.
package mouse_pkg;

  localparam logic [15:0] PORT_KEY = 16'hFADF;
  localparam logic [15:0] PORT_X   = 16'hFBDF;
  localparam logic [15:0] PORT_Y   = 16'hFFDF;

  localparam logic [7:0] KEY_RESET = 8'hFF;
  localparam logic [7:0] XY_RESET  = 8'h00;

  // Bit 3 of KEY always reads 1, so it is stored as 1.
  localparam logic [7:0] KEY_FIXED = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/mouse_strobe_sync.sv
// Async input synchroniser with optional
// rising-edge pulse output.
module mouse_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_lvl;

  assign w_lvl = r_sync[SYNC_STAGES-1];

  // Flop chain plus one-cycle history for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_lvl;
    end
  end

  assign o_out = LEVEL ? w_lvl : (w_lvl & ~r_prev);

endmodule

// File: rtl/kempston_mouse_sync.sv
// Kempston mouse port for the ZX BUS with
// synchronised MCU updates and a torn-read guard.
module kempston_mouse_sync
  import mouse_pkg::*;
#(
  parameter int BUTTONS     = 2,
  parameter int WHEEL       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int A15_QUAL    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MX,
  input  logic       MY,
  input  logic       MKEY,
  input  logic [7:0] DI,
  input  logic       A0,
  input  logic       A1,
  input  logic       A5,
  input  logic       A7,
  input  logic       A8,
  input  logic       A10,
  input  logic       A15,
  input  logic       M1,
  input  logic       RD,
  input  logic       IORQ,
  output logic       IORQGE,
  output logic [7:0] D
);

  logic       w_a15_ok;
  logic       w_match;
  logic       w_en;
  logic       w_sel_key;
  logic       w_sel_x;
  logic       w_sel_y;
  logic       w_drive;
  logic [7:0] w_key_byte;
  logic [7:0] w_dout;

  logic       w_upd_x;
  logic       w_upd_y;
  logic       w_upd_k;
  logic       w_en_s;
  logic [7:0] w_di_s;
  logic [7:0] w_key_in;

  logic [SYNC_STAGES-1:0][7:0] r_di;

  state_e     r_state;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_key;
  logic [7:0] r_pend_x;
  logic [7:0] r_pend_y;
  logic [7:0] r_pend_k;
  logic       r_pv_x;
  logic       r_pv_y;
  logic       r_pv_k;

  assign w_a15_ok = (A15_QUAL != 0) ? A15 : 1'b1;
  assign w_match  = A0 & A1 & A7 & M1 & ~A5 & w_a15_ok;
  assign IORQGE   = ~w_match;
  assign w_en     = w_match & ~RD & ~IORQ;

  assign w_sel_key = ({A10, A8} == {PORT_KEY[10], PORT_KEY[8]});
  assign w_sel_x   = ({A10, A8} == {PORT_X[10], PORT_X[8]});
  assign w_sel_y   = ({A10, A8} == {PORT_Y[10], PORT_Y[8]});

  assign w_key_byte = {
    (WHEEL != 0) ? r_key[7:4] : 4'hF,
    r_key[3],
    (BUTTONS == 3) ? r_key[2] : 1'b1,
    r_key[1:0]
  };

  // Read mux over the visible registers.
  always_comb begin
    w_dout  = 8'hFF;
    w_drive = 1'b0;
    unique case (1'b1)
      w_sel_key: begin
        w_dout  = w_key_byte;
        w_drive = w_en;
      end
      w_sel_x: begin
        w_dout  = r_x;
        w_drive = w_en;
      end
      w_sel_y: begin
        w_dout  = r_y;
        w_drive = w_en;
      end
      default: begin
        w_dout  = 8'hFF;
        w_drive = 1'b0;
      end
    endcase
  end

  assign D = w_drive ? w_dout : 8'bzzzz_zzzz;

  mouse_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .LEVEL(1'b0))
    u_sync_x (.i_clk(CLK), .i_rst(RST), .i_async(MX), .o_out(w_upd_x));

  mouse_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .LEVEL(1'b0))
    u_sync_y (.i_clk(CLK), .i_rst(RST), .i_async(MY), .o_out(w_upd_y));

  mouse_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .LEVEL(1'b0))
    u_sync_k (.i_clk(CLK), .i_rst(RST), .i_async(MKEY), .o_out(w_upd_k));

  mouse_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .LEVEL(1'b1))
    u_sync_en (.i_clk(CLK), .i_rst(RST), .i_async(w_en), .o_out(w_en_s));

  // DI delayed to line up with the strobe pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_di <= '0;
    end else begin
      r_di <= {r_di[SYNC_STAGES-2:0], DI};
    end
  end

  assign w_di_s   = r_di[SYNC_STAGES-1];
  assign w_key_in = w_di_s | KEY_FIXED;

  // Read guard: direct writes when idle, pending while busy;
  // the last busy cycle (en_s low) drains, fresh updates win.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_x      <= XY_RESET;
      r_y      <= XY_RESET;
      r_key    <= KEY_RESET;
      r_pend_x <= XY_RESET;
      r_pend_y <= XY_RESET;
      r_pend_k <= KEY_RESET;
      r_pv_x   <= 1'b0;
      r_pv_y   <= 1'b0;
      r_pv_k   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BUSY: begin
          if (w_en_s) begin
            if (w_upd_x) begin
              r_pend_x <= w_di_s;
              r_pv_x   <= 1'b1;
            end
            if (w_upd_y) begin
              r_pend_y <= w_di_s;
              r_pv_y   <= 1'b1;
            end
            if (w_upd_k) begin
              r_pend_k <= w_key_in;
              r_pv_k   <= 1'b1;
            end
          end else begin
            if (w_upd_x)     r_x <= w_di_s;
            else if (r_pv_x) r_x <= r_pend_x;
            if (w_upd_y)     r_y <= w_di_s;
            else if (r_pv_y) r_y <= r_pend_y;
            if (w_upd_k)     r_key <= w_key_in;
            else if (r_pv_k) r_key <= r_pend_k;
            r_pv_x  <= 1'b0;
            r_pv_y  <= 1'b0;
            r_pv_k  <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_IDLE, ST_DRAIN: begin
          if (w_upd_x) r_x   <= w_di_s;
          if (w_upd_y) r_y   <= w_di_s;
          if (w_upd_k) r_key <= w_key_in;
          r_state <= w_en_s ? ST_BUSY : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kempston_mouse_sync.sv
// Directed bench for kempston_mouse_sync:
// three builds share one stimulus stream.
module tb_kempston_mouse_sync;

  localparam int SS = 2;

  logic       clk;
  logic       rst;
  logic       mx;
  logic       my;
  logic       mkey;
  logic [7:0] di;
  logic       a0, a1, a5, a7, a8, a10, a15, m1;
  logic       rd;
  logic       iorq;

  logic       g0, g1, g2;
  wire  [7:0] d0, d1, d2;

  logic [7:0] pv0, pv1, pv2;
  logic       pg0, pg1, pg2;

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (d0[g]);
    pulldown (d1[g]);
    pulldown (d2[g]);
  end

  kempston_mouse_sync #(
    .BUTTONS(2), .WHEEL(1), .SYNC_STAGES(SS), .A15_QUAL(1)
  ) u0 (
    .CLK(clk), .RST(rst), .MX(mx), .MY(my), .MKEY(mkey), .DI(di),
    .A0(a0), .A1(a1), .A5(a5), .A7(a7), .A8(a8), .A10(a10),
    .A15(a15), .M1(m1), .RD(rd), .IORQ(iorq),
    .IORQGE(g0), .D(d0)
  );

  kempston_mouse_sync #(
    .BUTTONS(2), .WHEEL(0), .SYNC_STAGES(SS), .A15_QUAL(1)
  ) u1 (
    .CLK(clk), .RST(rst), .MX(mx), .MY(my), .MKEY(mkey), .DI(di),
    .A0(a0), .A1(a1), .A5(a5), .A7(a7), .A8(a8), .A10(a10),
    .A15(a15), .M1(m1), .RD(rd), .IORQ(iorq),
    .IORQGE(g1), .D(d1)
  );

  kempston_mouse_sync #(
    .BUTTONS(3), .WHEEL(1), .SYNC_STAGES(SS), .A15_QUAL(0)
  ) u2 (
    .CLK(clk), .RST(rst), .MX(mx), .MY(my), .MKEY(mkey), .DI(di),
    .A0(a0), .A1(a1), .A5(a5), .A7(a7), .A8(a8), .A10(a10),
    .A15(a15), .M1(m1), .RD(rd), .IORQ(iorq),
    .IORQGE(g2), .D(d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_addr(input logic [15:0] a);
    a0  = a[0];
    a1  = a[1];
    a5  = a[5];
    a7  = a[7];
    a8  = a[8];
    a10 = a[10];
    a15 = a[15];
  endtask

  // Short read that never spans a clock edge.
  task automatic peek(input logic [15:0] a);
    set_addr(a);
    m1   = 1'b1;
    rd   = 1'b0;
    iorq = 1'b0;
    #1;
    pv0 = d0;
    pv1 = d1;
    pv2 = d2;
    pg0 = g0;
    pg1 = g1;
    pg2 = g2;
    rd   = 1'b1;
    iorq = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    peek(16'hFADF);
    n_tests++;
    if (pv0 !== 8'hFF || pv1 !== 8'hFF || pv2 !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_key: got %h %h %h want ff", pv0, pv1, pv2);
    end
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h00 || pv2 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_x: got %h %h want 00", pv0, pv2);
    end
    peek(16'hFFDF);
    n_tests++;
    if (pv0 !== 8'h00 || pv2 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_y: got %h %h want 00", pv0, pv2);
    end
    set_addr(16'hFBDF);
    m1 = 1'b1;
    #1;
    n_tests++;
    if (g0 !== 1'b0) begin
      n_fail++;
      $display("FAIL iorqge_match: got %b want 0", g0);
    end
    m1 = 1'b0;
    #1;
    n_tests++;
    if (g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL iorqge_m1: got %b want 1", g0);
    end
    m1 = 1'b1;
    set_addr(16'hFBFF);
    #1;
    n_tests++;
    if (g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL iorqge_a5: got %b want 1", g0);
    end
    set_addr(16'h7BDF);
    #1;
    n_tests++;
    if (g0 !== 1'b1 || g2 !== 1'b0) begin
      n_fail++;
      $display("FAIL iorqge_a15: got %b %b want 1 0", g0, g2);
    end
  endtask

  task automatic test_mx_strobe;
    @(negedge clk);
    di = 8'h5A;
    mx = 1'b1;
    repeat (SS) @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL mx_early: got %h want 00", pv0);
    end
    @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h5A || pv1 !== 8'h5A || pv2 !== 8'h5A) begin
      n_fail++;
      $display("FAIL mx_commit: got %h %h %h want 5a", pv0, pv1, pv2);
    end
    @(posedge clk);
    @(negedge clk);
    mx = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_read_guard;
    set_addr(16'hFFDF);
    m1 = 1'b1;
    @(negedge clk);
    rd   = 1'b0;
    iorq = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (d0 !== 8'h00) begin
      n_fail++;
      $display("FAIL guard_start: got %h want 00", d0);
    end
    @(negedge clk);
    di = 8'h11;
    my = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (d0 !== 8'h00) begin
        n_fail++;
        $display("FAIL guard_hold11 c%0d: got %h want 00", i, d0);
      end
    end
    @(negedge clk);
    my = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    di = 8'h22;
    my = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (d0 !== 8'h00) begin
        n_fail++;
        $display("FAIL guard_hold22 c%0d: got %h want 00", i, d0);
      end
    end
    @(negedge clk);
    my = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rd   = 1'b1;
    iorq = 1'b1;
    repeat (SS) @(posedge clk);
    #1;
    peek(16'hFFDF);
    n_tests++;
    if (pv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL guard_early: got %h want 00", pv0);
    end
    @(posedge clk);
    #1;
    peek(16'hFFDF);
    n_tests++;
    if (pv0 !== 8'h22 || pv2 !== 8'h22) begin
      n_fail++;
      $display("FAIL guard_drain: got %h %h want 22", pv0, pv2);
    end
  endtask

  task automatic test_key_options;
    @(negedge clk);
    di   = 8'h30;
    mkey = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mkey = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    peek(16'hFADF);
    n_tests++;
    if (pv0 !== 8'h3C) begin
      n_fail++;
      $display("FAIL key_b2w1: got %h want 3c", pv0);
    end
    n_tests++;
    if (pv1 !== 8'hFC) begin
      n_fail++;
      $display("FAIL key_b2w0: got %h want fc", pv1);
    end
    n_tests++;
    if (pv2 !== 8'h38) begin
      n_fail++;
      $display("FAIL key_b3w1: got %h want 38", pv2);
    end
  endtask

  task automatic test_a15_qual;
    @(posedge clk);
    #1;
    peek(16'h7BDF);
    n_tests++;
    if (pg0 !== 1'b1 || pg1 !== 1'b1) begin
      n_fail++;
      $display("FAIL a15_ge_q1: got %b %b want 1", pg0, pg1);
    end
    n_tests++;
    if (pv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL a15_d_q1: got %h want 00 (undriven)", pv0);
    end
    n_tests++;
    if (pg2 !== 1'b0 || pv2 !== 8'h5A) begin
      n_fail++;
      $display("FAIL a15_q0: got %b %h want 0 5a", pg2, pv2);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    di = 8'hC3;
    mx = 1'b1;
    my = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mx = 1'b0;
    my = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_x: got %h want c3", pv0);
    end
    peek(16'hFFDF);
    n_tests++;
    if (pv0 !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_y: got %h want c3", pv0);
    end
  endtask

  task automatic test_reset_mid_read;
    set_addr(16'hFBDF);
    m1 = 1'b1;
    @(negedge clk);
    rd   = 1'b0;
    iorq = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    di = 8'h77;
    mx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (d0 !== 8'hC3) begin
      n_fail++;
      $display("FAIL rmr_frozen: got %h want c3", d0);
    end
    @(negedge clk);
    mx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (d0 !== 8'h00) begin
      n_fail++;
      $display("FAIL rmr_rstval: got %h want 00", d0);
    end
    @(negedge clk);
    rst  = 1'b0;
    rd   = 1'b1;
    iorq = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL rmr_lost: got %h want 00", pv0);
    end
    @(negedge clk);
    di = 8'h66;
    mx = 1'b1;
    repeat (SS) @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h00) begin
      n_fail++;
      $display("FAIL rmr_idle_early: got %h want 00", pv0);
    end
    @(posedge clk);
    #1;
    peek(16'hFBDF);
    n_tests++;
    if (pv0 !== 8'h66) begin
      n_fail++;
      $display("FAIL rmr_idle: got %h want 66", pv0);
    end
    @(negedge clk);
    mx = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    mx   = 1'b0;
    my   = 1'b0;
    mkey = 1'b0;
    di   = 8'h00;
    set_addr(16'h0000);
    m1   = 1'b1;
    rd   = 1'b1;
    iorq = 1'b1;
    pv0 = '0;
    pv1 = '0;
    pv2 = '0;
    pg0 = 1'b0;
    pg1 = 1'b0;
    pg2 = 1'b0;
    test_reset();
    test_mx_strobe();
    test_read_guard();
    test_key_options();
    test_a15_qual();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
